mmio_initiator: RTL and testbench

MMIO_INITIATOR -- requirements
Module: mmio_initiator

---
 rtl/mmio_pkg.sv | 25 ++
 rtl/mmio_timeout_counter.sv | 41 ++++
 rtl/mmio_initiator.sv | 127 ++++++++++++
 tb/tb_mmio_initiator.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/mmio_pkg.sv
// Shared MMIO definitions: initiator FSM encoding, timeout defaults and the MMIO address map.
package mmio_pkg;

  // Default bus timeout and the read data returned when a read is aborted.
  localparam int unsigned TimeoutCyclesDefault = 255;
  localparam logic [7:0]  TimeoutRdataDefault  = 8'hFF;

  // Initiator FSM encoding. Plain constants keep it usable from older tools.
  typedef logic [1:0] state_t;
  localparam state_t StIdle    = 2'd0;
  localparam state_t StReq     = 2'd1;
  localparam state_t StFinish  = 2'd2;
  localparam state_t StRecover = 2'd3;

  // MMIO address map.
  localparam logic [15:0] MmioAddrLed  = 16'h8000;
  localparam logic [15:0] MmioAddrUart = 16'h8010;
  localparam logic [15:0] MmioAddrGpio = 16'h8020;

  // Timeout counter width; never narrower than one bit.
  function automatic int unsigned cnt_width(input int unsigned cycles);
    return (cycles < 1) ? 1 : $clog2(cycles + 1);
  endfunction

endpackage

// File: rtl/mmio_timeout_counter.sv
// Cycle counter for the bus timeout: cleared on accept, counts while the request is held,
// flags the last permitted cycle.
module mmio_timeout_counter
  import mmio_pkg::*;
#(
  parameter int unsigned TimeoutCycles = TimeoutCyclesDefault
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic clear_i,
  input  logic enable_i,
  output logic expired_o
);

  localparam int unsigned    CntW    = cnt_width(TimeoutCycles);
  localparam logic [CntW-1:0] LastCnt = CntW'(TimeoutCycles - 1);

  logic [CntW-1:0] cnt_d, cnt_q;

  // Next count: clear wins, otherwise count up and hold at the last cycle.
  always_comb begin
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = '0;
    end else if (enable_i && (cnt_q != LastCnt)) begin
      cnt_d = cnt_q + CntW'(1);
    end
  end

  // Count register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired_o = (cnt_q == LastCnt);

endmodule

// File: rtl/mmio_initiator.sv
// CPU-side MMIO initiator: accepts one transaction at a time, drives a level request onto the
// bus until a responder completes or the timeout aborts it, then reports done/err to the CPU.
module mmio_initiator
  import mmio_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = TimeoutCyclesDefault,
  parameter logic [7:0]  TIMEOUT_RDATA  = TimeoutRdataDefault
) (
  input  logic        clock,
  input  logic        reset_n,
  // CPU side
  input  logic        cpu_req,
  input  logic        cpu_we,
  input  logic [15:0] cpu_addr,
  input  logic [7:0]  cpu_wdata,
  output logic        cpu_ready,
  output logic        cpu_done,
  output logic        cpu_err,
  output logic [7:0]  cpu_rdata,
  // Bus side
  output logic [15:0] mmio_addr,
  output logic [7:0]  mmio_data,
  output logic        mmio_we,
  output logic        mmio_req,
  input  logic        mmio_done,
  input  logic [7:0]  mmio_rdata
);

  state_t      state_d, state_q;
  logic [15:0] addr_d, addr_q;
  logic [7:0]  wdata_d, wdata_q;
  logic        we_d, we_q;
  logic [7:0]  rdata_d, rdata_q;
  logic        err_d, err_q;
  logic        cnt_clear;
  logic        cnt_enable;
  logic        cnt_expired;

  mmio_timeout_counter #(
    .TimeoutCycles(TIMEOUT_CYCLES)
  ) u_timeout (
    .clk_i    (clock),
    .rst_ni   (reset_n),
    .clear_i  (cnt_clear),
    .enable_i (cnt_enable),
    .expired_o(cnt_expired)
  );

  assign cnt_enable = (state_q == StReq);

  // FSM next state and datapath updates; mmio_done is only looked at in REQ.
  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    we_d      = we_q;
    rdata_d   = rdata_q;
    err_d     = err_q;
    cnt_clear = 1'b0;
    case (state_q)
      StIdle: begin
        if (cpu_req) begin
          addr_d    = cpu_addr;
          wdata_d   = cpu_wdata;
          we_d      = cpu_we;
          cnt_clear = 1'b1;
          state_d   = StReq;
        end
      end
      StReq: begin
        // Completion beats a simultaneous timeout.
        if (mmio_done) begin
          if (!we_q) begin
            rdata_d = mmio_rdata;
          end
          err_d   = 1'b0;
          state_d = StFinish;
        end else if (cnt_expired) begin
          if (!we_q) begin
            rdata_d = TIMEOUT_RDATA;
          end
          err_d   = 1'b1;
          state_d = StFinish;
        end
      end
      StFinish: begin
        state_d = StRecover;
      end
      StRecover: begin
        // One dead cycle lets level-style responders drop done before the next accept.
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= StIdle;
      addr_q  <= '0;
      wdata_q <= '0;
      we_q    <= 1'b0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      we_q    <= we_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  assign cpu_ready = (state_q == StIdle);
  assign cpu_done  = (state_q == StFinish);
  assign cpu_err   = (state_q == StFinish) && err_q;
  assign cpu_rdata = rdata_q;
  assign mmio_req  = (state_q == StReq);
  assign mmio_addr = addr_q;
  assign mmio_data = wdata_q;
  assign mmio_we   = we_q;

endmodule

// File: tb/tb_mmio_initiator.sv
// Scoreboard bench for mmio_initiator: stimulus queues expected completions, a monitor checks
// bus signals while requesting and every cpu_done against the queue.
module tb_mmio_initiator;
  import mmio_pkg::*;

  localparam int unsigned Tmo = 4;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        cpu_req = 1'b0;
  logic        cpu_we = 1'b0;
  logic [15:0] cpu_addr = '0;
  logic [7:0]  cpu_wdata = '0;
  logic        cpu_ready, cpu_done, cpu_err;
  logic [7:0]  cpu_rdata;
  logic [15:0] mmio_addr;
  logic [7:0]  mmio_data;
  logic        mmio_we, mmio_req, mmio_done;
  logic [7:0]  mmio_rdata;

  mmio_initiator #(
    .TIMEOUT_CYCLES(Tmo),
    .TIMEOUT_RDATA (8'hFF)
  ) u_dut (
    .clock     (clock),
    .reset_n   (reset_n),
    .cpu_req   (cpu_req),
    .cpu_we    (cpu_we),
    .cpu_addr  (cpu_addr),
    .cpu_wdata (cpu_wdata),
    .cpu_ready (cpu_ready),
    .cpu_done  (cpu_done),
    .cpu_err   (cpu_err),
    .cpu_rdata (cpu_rdata),
    .mmio_addr (mmio_addr),
    .mmio_data (mmio_data),
    .mmio_we   (mmio_we),
    .mmio_req  (mmio_req),
    .mmio_done (mmio_done),
    .mmio_rdata(mmio_rdata)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Responder: done on the resp_delay-th request cycle (0 = never), then held resp_hold more cycles.
  int         resp_delay = 0;
  int         resp_hold  = 0;
  logic [7:0] resp_data  = 8'h00;
  int         req_seen   = 0;
  int         hold_cnt   = 0;

  always @(posedge clock) begin
    req_seen <= mmio_req ? req_seen + 1 : 0;
    if (mmio_req && mmio_done) hold_cnt <= resp_hold;
    else if (hold_cnt > 0) hold_cnt <= hold_cnt - 1;
  end

  assign mmio_done  = (mmio_req && resp_delay != 0 && req_seen == resp_delay - 1) || (hold_cnt != 0);
  assign mmio_rdata = mmio_done ? resp_data : 8'hE7;

  typedef struct {
    logic        we;
    logic [15:0] addr;
    logic [7:0]  wdata;
    logic        err;
    logic [7:0]  rdata;
    int          cyc;
    int          nreq;
  } exp_t;

  exp_t q[$];
  int   req_cnt = 0;

  // Monitor: bus stability while requesting, and completion against the scoreboard.
  always @(negedge clock) begin
    exp_t e;
    if (!reset_n) begin
      req_cnt = 0;
    end else begin
      if (mmio_req) begin
        req_cnt++;
        if (q.size() == 0) begin
          chk("req_without_txn", 32'(mmio_req), 32'd0);
        end else begin
          chk("mmio_addr", 32'(mmio_addr), 32'(q[0].addr));
          chk("mmio_we", 32'(mmio_we), 32'(q[0].we));
          if (q[0].we) chk("mmio_data", 32'(mmio_data), 32'(q[0].wdata));
        end
      end
      if (cpu_done) begin
        if (q.size() == 0) begin
          chk("unexpected_done", 32'(cpu_done), 32'd0);
        end else begin
          e = q.pop_front();
          chk("cpu_err", 32'(cpu_err), 32'(e.err));
          chk("cpu_rdata", 32'(cpu_rdata), 32'(e.rdata));
          chk("done_cycle", 32'(cyc), 32'(e.cyc));
          chk("req_cycles", 32'(req_cnt), 32'(e.nreq));
          chk("mmio_req_low_at_done", 32'(mmio_req), 32'd0);
        end
        req_cnt = 0;
      end
    end
  end

  // Waits for ready, configures the responder, queues the expectation and pulses cpu_req.
  task automatic issue(input logic we, input logic [15:0] addr, input logic [7:0] wdata,
                       input int delay, input int hold, input logic [7:0] rd,
                       input logic exp_err, input logic [7:0] exp_rdata, input int nreq);
    exp_t e;
    int   n = 0;
    @(negedge clock);
    while (!cpu_ready && n < 50) begin
      @(negedge clock);
      n++;
    end
    if (!cpu_ready) begin
      chk("ready_timeout", 32'(cpu_ready), 32'd1);
      return;
    end
    resp_delay = delay;
    resp_hold  = hold;
    resp_data  = rd;
    e.we = we; e.addr = addr; e.wdata = wdata; e.err = exp_err; e.rdata = exp_rdata;
    e.cyc = cyc + nreq + 1; e.nreq = nreq;
    q.push_back(e);
    cpu_req = 1'b1; cpu_we = we; cpu_addr = addr; cpu_wdata = wdata;
    @(posedge clock);
    #1 cpu_req = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (q.size() != 0 && n < 60) begin
      @(negedge clock);
      n++;
    end
    if (q.size() != 0) begin
      chk("done_timeout", 32'(q.size()), 32'd0);
      q.delete();
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset values, checked with no clock edge involved.
    #3;
    chk("rst_mmio_req", 32'(mmio_req), 32'd0);
    chk("rst_cpu_done", 32'(cpu_done), 32'd0);
    chk("rst_cpu_err", 32'(cpu_err), 32'd0);
    chk("rst_cpu_rdata", 32'(cpu_rdata), 32'd0);
    chk("rst_mmio_addr", 32'(mmio_addr), 32'd0);
    chk("rst_mmio_data", 32'(mmio_data), 32'd0);
    chk("rst_mmio_we", 32'(mmio_we), 32'd0);
    repeat (3) @(negedge clock);
    reset_n = 1'b1;
    @(negedge clock);
    chk("ready_after_reset", 32'(cpu_ready), 32'd1);

    // we, addr, wdata, delay, hold, resp data, exp err, exp rdata, req cycles
    issue(1'b1, MmioAddrLed,  8'h2A, 1, 0, 8'h00, 1'b0, 8'h00, 1);  // one-cycle write
    issue(1'b0, MmioAddrUart, 8'h00, 4, 0, 8'h5C, 1'b0, 8'h5C, 4);  // done on last timeout cycle
    issue(1'b0, 16'h1234,     8'h00, 3, 0, 8'h3C, 1'b0, 8'h3C, 3);
    issue(1'b0, 16'hDEAD,     8'h00, 0, 0, 8'h00, 1'b1, 8'hFF, 4);  // unmapped read times out
    issue(1'b1, MmioAddrLed,  8'h55, 2, 0, 8'h99, 1'b0, 8'hFF, 2);  // write keeps old rdata
    issue(1'b0, MmioAddrUart, 8'h00, 1, 3, 8'h11, 1'b0, 8'h11, 1);  // responder holds done
    issue(1'b0, MmioAddrUart, 8'h00, 0, 0, 8'h22, 1'b1, 8'hFF, 4);  // back-to-back, no done
    issue(1'b0, MmioAddrGpio, 8'h00, 2, 0, 8'hC3, 1'b0, 8'hC3, 2);
    issue(1'b1, MmioAddrGpio, 8'h6B, 0, 0, 8'h00, 1'b1, 8'hC3, 4);  // write timeout
    drain();

    // cpu_req while busy is ignored and not queued.
    issue(1'b0, MmioAddrLed, 8'h00, 3, 0, 8'h77, 1'b0, 8'h77, 3);
    @(negedge clock);
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 16'hBEEF; cpu_wdata = 8'hAA;
    @(posedge clock);
    #1 cpu_req = 1'b0;
    drain();
    repeat (8) @(negedge clock);
    chk("no_queued_req", 32'(mmio_req), 32'd0);
    chk("idle_after_ignore", 32'(cpu_ready), 32'd1);

    // Reset in the middle of a request: bus drops at once, no completion.
    issue(1'b0, MmioAddrUart, 8'h00, 0, 0, 8'h00, 1'b1, 8'hFF, 4);
    @(negedge clock);
    #2 reset_n = 1'b0;
    q.delete();
    #1;
    chk("rst_mid_mmio_req", 32'(mmio_req), 32'd0);
    chk("rst_mid_cpu_done", 32'(cpu_done), 32'd0);
    chk("rst_mid_mmio_addr", 32'(mmio_addr), 32'd0);
    repeat (2) @(negedge clock);
    reset_n = 1'b1;
    repeat (6) @(negedge clock);
    chk("post_rst_rdata", 32'(cpu_rdata), 32'd0);
    chk("post_rst_ready", 32'(cpu_ready), 32'd1);

    issue(1'b0, MmioAddrUart, 8'h00, 1, 0, 8'h99, 1'b0, 8'h99, 1);
    drain();
    repeat (4) @(negedge clock);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
